// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew values,
// forward-select codes for the D and E stages, and mult/div start codes.
package hazard_pkg;

    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_NOW  = 2'd0;

    localparam logic [1:0] FWD_D_RF  = 2'd0;
    localparam logic [1:0] FWD_D_E   = 2'd1;
    localparam logic [1:0] FWD_D_M   = 2'd2;
    localparam logic [1:0] FWD_D_W   = 2'd3;

    localparam logic [1:0] FWD_E_IDEX = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A stage blocks lower-priority sources once its wa matches, even if not ready.
    function automatic logic [1:0] d_fwd_sel(
        input logic [4:0] src,
        input logic [4:0] e_wa, input logic [1:0] e_tnew,
        input logic [4:0] m_wa, input logic [1:0] m_tnew,
        input logic [4:0] w_wa
    );
        logic [1:0] sel;
        sel = FWD_D_RF;
        if (e_wa != 5'd0 && src == e_wa)
            sel = (e_tnew == TNEW_NOW) ? FWD_D_E : FWD_D_RF;
        else if (m_wa != 5'd0 && src == m_wa)
            sel = (m_tnew == TNEW_NOW) ? FWD_D_M : FWD_D_RF;
        else if (w_wa != 5'd0 && src == w_wa)
            sel = FWD_D_W;
        return sel;
    endfunction

    function automatic logic [1:0] e_fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_wa, input logic [1:0] m_tnew,
        input logic [4:0] w_wa
    );
        logic [1:0] sel;
        sel = FWD_E_IDEX;
        if (m_wa != 5'd0 && src == m_wa)
            sel = (m_tnew == TNEW_NOW) ? FWD_E_M : FWD_E_IDEX;
        else if (w_wa != 5'd0 && src == w_wa)
            sel = FWD_E_W;
        return sel;
    endfunction

    function automatic logic src_stall(
        input logic [4:0] src, input logic [1:0] tuse,
        input logic [4:0] e_wa, input logic [1:0] e_tnew,
        input logic [4:0] m_wa, input logic [1:0] m_tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               ((src == e_wa && tuse < e_tnew) || (src == m_wa && tuse < m_tnew));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Tracks the multi-cycle mult/div unit: a start seen while idle loads the
// matching latency, and md_busy_o stays high for exactly that many cycles.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] md_start_i,
    output logic       md_busy_o,
    output logic       state_o
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    md_state_e      state_q;
    logic [CW-1:0]  count_q;
    logic           busy_q;

    // Starts arriving while BUSY are dropped; the reserved code acts as none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start_i == MD_MULT) begin
                        state_q <= MD_BUSY;
                        count_q <= CW'(MULT_CYC);
                        busy_q  <= 1'b1;
                    end else if (md_start_i == MD_DIV) begin
                        state_q <= MD_BUSY;
                        count_q <= CW'(DIV_CYC);
                        busy_q  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (count_q == CW'(1)) begin
                        state_q <= MD_IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy_o = busy_q;
    assign state_o   = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: D-stage stall decision, D/E operand
// forward selects, mult/div busy tracking and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_rs_tuse,
    input  logic [1:0]       d_rt_tuse,
    input  logic             d_md,
    input  logic [4:0]       e_rs,
    input  logic [4:0]       e_rt,
    input  logic [4:0]       e_wa,
    input  logic [4:0]       m_wa,
    input  logic [4:0]       w_wa,
    input  logic [1:0]       e_tnew,
    input  logic [1:0]       m_tnew,
    input  logic [1:0]       e_md_start,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_clr,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             md_state;
    logic             data_stall;
    logic             md_stall;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_start_i (e_md_start),
        .md_busy_o  (md_busy),
        .state_o    (md_state)
    );

    always_comb begin
        data_stall = src_stall(d_rs, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew) ||
                     src_stall(d_rt, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);
        // A start in E this cycle counts as busy even before the timer reacts.
        md_stall   = d_md && (md_busy || e_md_start == MD_MULT || e_md_start == MD_DIV);
        stall      = data_stall || md_stall;
        pc_en      = !stall;
        fd_en      = !stall;
        de_clr     = stall;
        fwd_d_rs   = d_fwd_sel(d_rs, e_wa, e_tnew, m_wa, m_tnew, w_wa);
        fwd_d_rt   = d_fwd_sel(d_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa);
        fwd_e_rs   = e_fwd_sel(e_rs, m_wa, m_tnew, w_wa);
        fwd_e_rt   = e_fwd_sel(e_rt, m_wa, m_tnew, w_wa);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
    logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew, e_md_start;
    logic        d_md;
    logic        pc_en, fd_en, de_clr, md_busy;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [15:0] stall_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [15:0] exp_cnt;

    hazard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_md       (d_md),
        .e_rs       (e_rs),
        .e_rt       (e_rt),
        .e_wa       (e_wa),
        .m_wa       (m_wa),
        .w_wa       (w_wa),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .de_clr     (de_clr),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        d_rs = 0; d_rt = 0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3; d_md = 0;
        e_rs = 0; e_rt = 0; e_wa = 0; m_wa = 0; w_wa = 0;
        e_tnew = 0; m_tnew = 0; e_md_start = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further #2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag, input logic exp_stall);
        #2;
        check({tag, "_pc_en"}, 32'(pc_en), 32'(!exp_stall));
        check({tag, "_fd_en"}, 32'(fd_en), 32'(!exp_stall));
        check({tag, "_de_clr"}, 32'(de_clr), 32'(exp_stall));
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        d_rs_tuse = 0; d_rt_tuse = 0;
        #3;
        check("rst_md_busy", 32'(md_busy), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check_stall("rst", 1'b0);
        check("rst_fwd_d_rs", 32'(fwd_d_rs), 0);
        check("rst_fwd_d_rt", 32'(fwd_d_rt), 0);
        check("rst_fwd_e_rs", 32'(fwd_e_rs), 0);
        check("rst_fwd_e_rt", 32'(fwd_e_rt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        step();

        // Data stall on rs from E
        clear_inputs();
        d_rs = 8; d_rs_tuse = 0; e_wa = 8; e_tnew = 1;
        check_stall("e_stall", 1'b1);
        step(); exp_cnt++;
        clear_inputs();
        #2 check("e_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // E wins over M
        step();
        d_rs = 8; d_rs_tuse = 1; m_wa = 8; m_tnew = 0; e_wa = 8; e_tnew = 0;
        check_stall("e_over_m", 1'b0);
        check("e_over_m_fwd", 32'(fwd_d_rs), 1);
        e_wa = 0;
        #1 check("m_fwd_d", 32'(fwd_d_rs), 2);
        m_wa = 0; w_wa = 8;
        #1 check("w_fwd_d", 32'(fwd_d_rs), 3);
        // E matches but not ready: blocks W, and tuse 1 is not < tnew 1
        e_wa = 8; e_tnew = 1;
        #1 check("e_block_fwd", 32'(fwd_d_rs), 0);
        check("e_block_nostall", 32'(pc_en), 1);

        // Register zero never stalls or forwards
        step(); clear_inputs();
        d_rt = 0; d_rt_tuse = 0; e_wa = 0; e_tnew = 2;
        check_stall("r0", 1'b0);
        check("r0_fwd_d_rt", 32'(fwd_d_rt), 0);

        // rt stall from M, and tuse NONE suppresses it
        step(); clear_inputs();
        d_rt = 5; d_rt_tuse = 0; m_wa = 5; m_tnew = 1;
        check_stall("m_stall_rt", 1'b1);
        check("m_stall_rt_fwd", 32'(fwd_d_rt), 0);
        step(); exp_cnt++;
        d_rt_tuse = 3;
        check_stall("tuse_none", 1'b0);
        check("m_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // E-stage forwarding
        step(); clear_inputs();
        e_rs = 3; e_rt = 4; m_wa = 3; m_tnew = 0; w_wa = 3;
        #2 check("e_fwd_m", 32'(fwd_e_rs), 1);
        check("e_fwd_rt_none", 32'(fwd_e_rt), 0);
        m_tnew = 1;
        #1 check("e_fwd_m_block", 32'(fwd_e_rs), 0);
        m_wa = 0;
        #1 check("e_fwd_w", 32'(fwd_e_rs), 2);
        w_wa = 4;
        #1 check("e_fwd_rt_w", 32'(fwd_e_rt), 2);

        // Div start with d_md held: 11 stalled cycles; a mult start mid-busy is ignored
        step(); clear_inputs();
        d_md = 1; e_md_start = 2'b10;
        check_stall("div_start", 1'b1);
        check("div_start_busy", 32'(md_busy), 0);
        step(); exp_cnt++;
        e_md_start = 0;
        for (int i = 0; i < 10; i++) begin
            e_md_start = (i == 3) ? 2'b01 : 2'b00;
            #2;
            check($sformatf("div_busy_%0d", i), 32'(md_busy), 1);
            check($sformatf("div_stall_%0d", i), 32'(pc_en), 0);
            step(); exp_cnt++;
        end
        e_md_start = 0;
        #2 check("div_done_busy", 32'(md_busy), 0);
        check("div_done_pc_en", 32'(pc_en), 1);
        check("div_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // Reserved start code is not a start
        e_md_start = 2'b11;
        check_stall("md_rsvd", 1'b0);
        step(); e_md_start = 0;
        #2 check("md_rsvd_busy", 32'(md_busy), 0);

        // Mult then asynchronous reset mid-BUSY
        step(); clear_inputs();
        e_md_start = 2'b01;
        step(); exp_cnt++;
        e_md_start = 0; d_md = 1;
        #2 check("mult_busy", 32'(md_busy), 1);
        step(); exp_cnt++;
        step(); exp_cnt++;
        check("mult_still_busy", 32'(md_busy), 1);
        #2 rst_n = 1'b0;
        #1 check("arst_busy", 32'(md_busy), 0);
        check("arst_cnt", 32'(stall_cnt), 0);
        check("arst_pc_en", 32'(pc_en), 1);
        @(negedge clk) rst_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) step();
        check_stall("post_rst", 1'b0);
        check("post_rst_busy", 32'(md_busy), 0);
        check("post_rst_cnt", 32'(stall_cnt), 0);

        // Simultaneous data + MD stall counts once per cycle
        clear_inputs();
        d_md = 1; e_md_start = 2'b01; d_rs = 9; d_rs_tuse = 0; e_wa = 9; e_tnew = 2;
        check_stall("both_stall", 1'b1);
        step(); clear_inputs();
        #2 check("both_stall_cnt", 32'(stall_cnt), 1);
        for (int i = 0; i < 6; i++) step();
        check("mult_release", 32'(md_busy), 0);

        // Saturation: counter is at 1, run 65534 more stalled cycles to reach all ones
        d_rs = 8; d_rs_tuse = 0; e_wa = 8; e_tnew = 1;
        repeat (65533) step();
        #2 check("pre_sat_cnt", 32'(stall_cnt), 32'hFFFE);
        step();
        #2 check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        repeat (3) step();
        #2 check("sat_hold_cnt", 32'(stall_cnt), 32'hFFFF);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
